// File: rtl/control_fsm_pkg.sv
// Shared constants for the multicycle RISC-V control unit: state codes,
// opcodes, datapath select encodings and the control word layout.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10,
    S11 = 4'd11,
    S12 = 4'd12,
    S13 = 4'd13
  } stateT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic [1:0] pcSource;
    logic [1:0] aluOp;
    logic [1:0] aluSrcB;
    logic       aluSrcA;
    logic       regWrite;
    logic       regDst;
  } ctrlT;

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
interface control_fsm_if;
  logic [6:0] op;
  logic [3:0] state;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0;
  logic ALUSrcA, RegWrite, RegDst;

  modport master (
    input  op,
    output state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1,
           ALUSrcB0, ALUSrcA, RegWrite, RegDst
  );

  modport slave (
    output op,
    input  state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1,
           ALUSrcB0, ALUSrcA, RegWrite, RegDst
  );
endinterface

// File: rtl/control_fsm_decode.sv
// Moore output ROM: current state -> datapath control word.
module control_fsm_decode
  import control_fsm_pkg::*;
(
  input  stateT state,
  output ctrlT  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S0: begin
        ctrl.memRead = 1'b1;
        ctrl.irWrite = 1'b1;
        ctrl.pcWrite = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
      end
      S1: ctrl.aluSrcB = SRCB_IMMSH;
      S2: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S3: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S4: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
      end
      S5: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      S6: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S7: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S8: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = ALUOP_BRANCH;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      S10: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S11: ctrl.aluSrcB = SRCB_IMM;
      S12: begin
        ctrl.aluSrcA  = 1'b1;
        ctrl.aluSrcB  = SRCB_IMM;
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JALR;
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S13: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V control unit: state register and opcode-driven
// next-state logic; outputs come from the state-decode ROM.
module control_fsm
  import control_fsm_pkg::*;
(
  input  logic clk,
  input  logic reset,
  control_fsm_if.master bus
);

  stateT state, nextState;
  ctrlT  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else       state <= nextState;
  end

  always_comb begin
    nextState = S0;
    case (state)
      S0: nextState = S1;
      S1: begin
        case (bus.op)
          OP_LOAD, OP_STORE: nextState = S2;
          OP_R:              nextState = S6;
          OP_IALU:           nextState = S13;
          OP_BRANCH:         nextState = S8;
          OP_JAL:            nextState = S10;
          OP_LUI, OP_AUIPC:  nextState = S11;
          OP_JALR:           nextState = S12;
          default:           nextState = S0;
        endcase
      end
      S2:            nextState = (bus.op == OP_LOAD) ? S3 : S5;
      S3:            nextState = S4;
      S6, S11, S13:  nextState = S7;
      default:       nextState = S0;
    endcase
  end

  control_fsm_decode uDecode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign bus.state       = state;
  assign bus.PCWrite     = ctrl.pcWrite;
  assign bus.PCWriteCond = ctrl.pcWriteCond;
  assign bus.IorD        = ctrl.iorD;
  assign bus.MemRead     = ctrl.memRead;
  assign bus.MemWrite    = ctrl.memWrite;
  assign bus.IRWrite     = ctrl.irWrite;
  assign bus.MemtoReg    = ctrl.memtoReg;
  assign bus.PCSource1   = ctrl.pcSource[1];
  assign bus.PCSource0   = ctrl.pcSource[0];
  assign bus.ALUOp1      = ctrl.aluOp[1];
  assign bus.ALUOp0      = ctrl.aluOp[0];
  assign bus.ALUSrcB1    = ctrl.aluSrcB[1];
  assign bus.ALUSrcB0    = ctrl.aluSrcB[0];
  assign bus.ALUSrcA     = ctrl.aluSrcA;
  assign bus.RegWrite    = ctrl.regWrite;
  assign bus.RegDst      = ctrl.regDst;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: instruction-level reference model checked every
// cycle, plus directed state sequences with literal output patterns.
module tb_control_fsm;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  control_fsm_if bus ();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit positions of the 16-bit output vector used for comparison.
  localparam int B_PCWRITE = 15, B_PCWCOND = 14, B_IORD = 13, B_MEMREAD = 12;
  localparam int B_MEMWRITE = 11, B_IRWRITE = 10, B_MEMTOREG = 9;
  localparam int B_PCSRC1 = 8, B_PCSRC0 = 7, B_ALUOP1 = 6, B_ALUOP0 = 5;
  localparam int B_SRCB1 = 4, B_SRCB0 = 3, B_SRCA = 2, B_REGWRITE = 1, B_REGDST = 0;

  function automatic logic [15:0] dutOut();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.PCSource1, bus.PCSource0,
            bus.ALUOp1, bus.ALUOp0, bus.ALUSrcB1, bus.ALUSrcB0,
            bus.ALUSrcA, bus.RegWrite, bus.RegDst};
  endfunction

  // Which signals each step of an instruction asserts.
  function automatic logic [15:0] expOut(input int s);
    logic [15:0] v;
    v = '0;
    case (s)
      0:  begin v[B_MEMREAD] = 1; v[B_IRWRITE] = 1; v[B_PCWRITE] = 1; v[B_SRCB0] = 1; end
      1:  begin v[B_SRCB1] = 1; v[B_SRCB0] = 1; end
      2:  begin v[B_SRCA] = 1; v[B_SRCB1] = 1; end
      3:  begin v[B_MEMREAD] = 1; v[B_IORD] = 1; end
      4:  begin v[B_REGWRITE] = 1; v[B_MEMTOREG] = 1; end
      5:  begin v[B_MEMWRITE] = 1; v[B_IORD] = 1; end
      6:  begin v[B_SRCA] = 1; v[B_ALUOP1] = 1; end
      7:  begin v[B_REGWRITE] = 1; v[B_REGDST] = 1; end
      8:  begin v[B_SRCA] = 1; v[B_ALUOP0] = 1; v[B_PCWCOND] = 1; v[B_PCSRC0] = 1; end
      10: begin v[B_PCWRITE] = 1; v[B_PCSRC1] = 1; v[B_REGWRITE] = 1; v[B_REGDST] = 1; end
      11: begin v[B_SRCB1] = 1; end
      12: begin v[B_SRCA] = 1; v[B_SRCB1] = 1; v[B_PCWRITE] = 1; v[B_PCSRC1] = 1;
                v[B_PCSRC0] = 1; v[B_REGWRITE] = 1; v[B_REGDST] = 1; end
      13: begin v[B_SRCA] = 1; v[B_SRCB1] = 1; v[B_ALUOP1] = 1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Steps an instruction walks through after decode, before returning to fetch.
  function automatic void pathFor(input logic [6:0] opc, output int p[$]);
    p = {};
    case (opc)
      7'b0000011: p = {2, 3, 4};
      7'b0100011: p = {2, 5};
      7'b0110011: p = {6, 7};
      7'b0010011: p = {13, 7};
      7'b0110111, 7'b0010111: p = {11, 7};
      7'b1100011: p = {8};
      7'b1101111: p = {10};
      7'b1100111: p = {12};
      default: p = {};
    endcase
  endfunction

  int mState = 0;
  int pending[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0;
      pending = {};
    end else if (mState == 1) begin
      pathFor(bus.op, pending);
      mState = (pending.size() > 0) ? pending.pop_front() : 0;
    end else if (pending.size() > 0) begin
      mState = pending.pop_front();
    end else begin
      mState = (mState == 0) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (int'(bus.state) != mState) begin
      errors++;
      $display("FAIL model_state t=%0t got=%0d want=%0d", $time, bus.state, mState);
    end
    checks++;
    if (dutOut() !== expOut(mState)) begin
      errors++;
      $display("FAIL model_outputs t=%0t state=%0d got=%h want=%h",
               $time, mState, dutOut(), expOut(mState));
    end
  end

  // Walks n states from fetch (at a negedge), checking each literally; optionally
  // pins the full output vector at step litStep and scrambles op after step chgStep.
  task automatic runSeq(input string name, input logic [6:0] opc, input int n,
                        input int e0, input int e1, input int e2, input int e3,
                        input int e4, input int e5,
                        input int litStep, input logic [15:0] litVec,
                        input int chgStep);
    int e[6];
    e = '{e0, e1, e2, e3, e4, e5};
    bus.op = opc;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (int'(bus.state) != e[i]) begin
        errors++;
        $display("FAIL %s step%0d state got=%0d want=%0d", name, i, bus.state, e[i]);
      end
      if (i == litStep) begin
        checks++;
        if (dutOut() !== litVec) begin
          errors++;
          $display("FAIL %s step%0d outputs got=%h want=%h", name, i, dutOut(), litVec);
        end
      end
      if (i == chgStep) bus.op = 7'b1111111;
      if (i < n - 1) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    bus.op = 7'b0110011;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.state !== 4'd0 || dutOut() !== 16'h9408) begin
      errors++;
      $display("FAIL reset_state got=%0d/%h want=0/9408", bus.state, dutOut());
    end
    reset = 1'b0;

    runSeq("r_type", 7'b0110011, 5, 0, 1, 6, 7, 0, 0, 3, 16'h0003, -1);
    runSeq("load",   7'b0000011, 6, 0, 1, 2, 3, 4, 0, 3, 16'h3000, -1);
    runSeq("load_wb",7'b0000011, 6, 0, 1, 2, 3, 4, 0, 4, 16'h0202, 3);
    runSeq("store",  7'b0100011, 5, 0, 1, 2, 5, 0, 0, 3, 16'h2800, -1);
    runSeq("branch", 7'b1100011, 4, 0, 1, 8, 0, 0, 0, 2, 16'h40A4, -1);
    runSeq("jal",    7'b1101111, 4, 0, 1, 10, 0, 0, 0, 2, 16'h8103, -1);
    runSeq("jalr",   7'b1100111, 4, 0, 1, 12, 0, 0, 0, 2, 16'h8197, -1);
    runSeq("lui",    7'b0110111, 5, 0, 1, 11, 7, 0, 0, 2, 16'h0010, -1);
    runSeq("auipc",  7'b0010111, 5, 0, 1, 11, 7, 0, 0, 2, 16'h0010, -1);
    runSeq("i_alu",  7'b0010011, 5, 0, 1, 13, 7, 0, 0, 2, 16'h0054, -1);
    runSeq("unknown",7'b1111111, 3, 0, 1, 0, 0, 0, 0, 2, 16'h9408, -1);

    // Asynchronous reset in the middle of a load, clear of any clock edge.
    runSeq("pre_rst",7'b0000011, 4, 0, 1, 2, 3, 0, 0, 3, 16'h3000, -1);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || dutOut() !== 16'h9408) begin
      errors++;
      $display("FAIL async_reset got=%0d/%h want=0/9408", bus.state, dutOut());
    end
    @(negedge clk);
    reset = 1'b0;
    runSeq("post_rst", 7'b0000011, 6, 0, 1, 2, 3, 4, 0, 4, 16'h0202, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
